// File: rtl/cpu_types_pkg.sv
// Shared core types: hazard FSM states and the opcode/funct values hazard detection decodes.
package cpu_types_pkg;

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, HALT} hazard_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  function automatic logic reads_rs(input logic [5:0] op);
    return !(op == OP_J || op == OP_JAL || op == OP_LUI || op == OP_HALT);
  endfunction

  // Store data (SW rt) is forwarded, so only ALU and branch operands count here.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection between the EX-stage load and the DE-stage instruction.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic [31:0] instru_de,
  input  logic        dREN_ex,
  input  logic [4:0]  regDst_ex,
  output logic        lu_hit,
  output logic        jr_hit
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_match;
  logic       rt_match;
  logic       load_live;
  logic       unused_bits;

  always_comb begin
    opcode      = instru_de[31:26];
    rs          = instru_de[25:21];
    rt          = instru_de[20:16];
    funct       = instru_de[5:0];
    unused_bits = ^instru_de[15:6];
    load_live   = dREN_ex && (regDst_ex != '0);
    rs_match    = reads_rs(opcode) && (rs == regDst_ex);
    rt_match    = reads_rt(opcode) && (rt == regDst_ex);
    lu_hit      = load_live && (rs_match || rt_match);
    jr_hit      = load_live && (opcode == OP_RTYPE) && (funct == FUNCT_JR) && (rs == regDst_ex);
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline latch enable/flush control for the 5-stage core.
// Define HAZARD_PERF_EN to add the lu_cycles/mem_cycles/if_cycles stall counters.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 2,
  parameter int unsigned JR_BUBBLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] instru_de,
  input  logic        dREN_ex,
  input  logic [4:0]  regDst_ex,
  input  logic        dREN_me,
  input  logic        dWEN_me,
  input  logic        pcsel_ex,
  input  logic        jump_de,
  input  logic        halt_wb,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        mw_flush,
  output logic        halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] lu_cycles,
  output logic [31:0] mem_cycles,
  output logic [31:0] if_cycles
`endif
);

  hazard_state_t state;
  hazard_state_t ret_state;
  hazard_state_t eff_state;
  logic [1:0]    bcnt;
  logic          lu_jr;
  logic [2:0]    need;
  logic          lu_hit;
  logic          jr_hit;
  logic          mem_stall;
  logic          go_halt;
  logic          do_mem;
  logic          do_bubble;
  logic          lu_start;
  logic          bubble_last;
  logic          do_ifmiss;

  hazard_detect u_detect (
    .instru_de (instru_de),
    .dREN_ex   (dREN_ex),
    .regDst_ex (regDst_ex),
    .lu_hit    (lu_hit),
    .jr_hit    (jr_hit)
  );

  always_comb begin
    // MEM_WAIT is a freeze overlay: once dhit arrives the saved state acts in the same cycle.
    eff_state = (state == MEM_WAIT) ? ret_state : state;
    mem_stall = (dREN_me | dWEN_me) & ~dhit;
    go_halt   = 1'b0;
    do_mem    = 1'b0;
    do_bubble = 1'b0;
    lu_start  = 1'b0;
    do_ifmiss = 1'b0;
    need      = lu_jr ? 3'(JR_BUBBLES) : 3'(LU_BUBBLES);
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    de_en     = 1'b1;
    em_en     = 1'b1;
    mw_en     = 1'b1;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    em_flush  = 1'b0;
    mw_flush  = 1'b0;
    halted    = 1'b0;
    if (RST) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
      {fd_flush, de_flush, em_flush, mw_flush} = '1;
    end else if (state == HALT || halt_wb) begin
      go_halt = 1'b1;
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
      halted = 1'b1;
    end else if (mem_stall) begin
      do_mem = 1'b1;
      {pc_en, fd_en, de_en, em_en} = '0;
      mw_flush = 1'b1;
    end else if (eff_state == LU_STALL) begin
      do_bubble = 1'b1;
    end else if (pcsel_ex) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (lu_hit) begin
      // A jump in DE is itself the stalled consumer, so only an EX redirect cancels the stall.
      do_bubble = 1'b1;
      lu_start  = 1'b1;
      need      = jr_hit ? 3'(JR_BUBBLES) : 3'(LU_BUBBLES);
    end else if (jump_de) begin
      fd_flush = 1'b1;
    end else if (!ihit) begin
      do_ifmiss = 1'b1;
      pc_en     = 1'b0;
      fd_flush  = 1'b1;
    end
    if (do_bubble) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
    bubble_last = (lu_start ? 3'd1 : ({1'b0, bcnt} + 3'd1)) == need;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      ret_state <= RUN;
      bcnt      <= '0;
      lu_jr     <= 1'b0;
    end else if (go_halt) begin
      state <= HALT;
    end else if (do_mem) begin
      if (state != MEM_WAIT) ret_state <= state;
      state <= MEM_WAIT;
    end else if (do_bubble) begin
      if (lu_start) lu_jr <= jr_hit;
      if (bubble_last) begin
        state <= RUN;
        bcnt  <= '0;
      end else begin
        state <= LU_STALL;
        bcnt  <= (lu_start ? 2'd0 : bcnt) + 2'd1;
      end
    end else begin
      state <= RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      lu_cycles  <= '0;
      mem_cycles <= '0;
      if_cycles  <= '0;
    end else begin
      if (do_bubble) lu_cycles  <= lu_cycles + 32'd1;
      if (do_mem)    mem_cycles <= mem_cycles + 32'd1;
      if (do_ifmiss) if_cycles  <= if_cycles + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = do_ifmiss;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus randomized traffic.
module tb_hazard_unit;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, dREN_ex, dREN_me, dWEN_me, pcsel_ex, jump_de, halt_wb;
  logic [31:0] instru_de;
  logic [4:0]  regDst_ex;
  logic        pc_en, fd_en, de_en, em_en, mw_en;
  logic        fd_flush, de_flush, em_flush, mw_flush, halted;

  always #5 CLK = ~CLK;

  hazard_unit #(.LU_BUBBLES(2), .JR_BUBBLES(1)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .instru_de(instru_de),
    .dREN_ex(dREN_ex), .regDst_ex(regDst_ex), .dREN_me(dREN_me), .dWEN_me(dWEN_me),
    .pcsel_ex(pcsel_ex), .jump_de(jump_de), .halt_wb(halt_wb),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
    .halted(halted)
  );

  // {pc, fd, de, em, mw enables, fd, de, em, mw flushes, halted}
  localparam logic [9:0] V_RST   = 10'b00000_1111_0;
  localparam logic [9:0] V_HALT  = 10'b00000_0000_1;
  localparam logic [9:0] V_MEM   = 10'b00001_0001_0;
  localparam logic [9:0] V_BUB   = 10'b00111_0100_0;
  localparam logic [9:0] V_REDIR = 10'b11111_1100_0;
  localparam logic [9:0] V_JUMP  = 10'b11111_1000_0;
  localparam logic [9:0] V_IFM   = 10'b01111_1000_0;
  localparam logic [9:0] V_RUN   = 10'b11111_0000_0;

  localparam logic [31:0] I_ADD = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_JR  = {6'h00, 5'd2, 15'd0, 6'h08};
  localparam logic [31:0] I_SW  = {6'h2B, 5'd5, 5'd2, 16'd0};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          m_halted;
  int          m_left;
  logic [9:0]  last_obs;
  int          k;
  logic [5:0]  ops [10] = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02, 6'h03, 6'h3F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] obs();
    return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush, halted};
  endfunction

  // Reference hazard rules: which DE operands the load result feeds, and bubble count.
  function automatic bit lu_model(input logic [31:0] ins, input logic ld, input logic [4:0] dst,
                                  output int bubbles);
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit uses_rs, uses_rt, is_jr;
    op = ins[31:26];
    rs = ins[25:21];
    rt = ins[20:16];
    uses_rs = !(op inside {6'h02, 6'h03, 6'h0F, 6'h3F});
    uses_rt = op inside {6'h00, 6'h04, 6'h05};
    is_jr   = (op == 6'h00) && (ins[5:0] == 6'h08);
    bubbles = (is_jr && rs == dst) ? 1 : 2;
    return ld && dst != 5'd0 && ((uses_rs && rs == dst) || (uses_rt && rt == dst));
  endfunction

  task automatic cycle(input string tag);
    logic [9:0] e;
    int nb;
    bit hit;
    #2;
    hit = lu_model(instru_de, dREN_ex, regDst_ex, nb);
    if (RST) begin
      e = V_RST; m_halted = 0; m_left = 0;
    end else if (m_halted || halt_wb) begin
      e = V_HALT; m_halted = 1;
    end else if ((dREN_me || dWEN_me) && !dhit) begin
      e = V_MEM;
    end else if (m_left > 0) begin
      e = V_BUB; m_left--;
    end else if (pcsel_ex) begin
      e = V_REDIR;
    end else if (hit) begin
      e = V_BUB; m_left = nb - 1;
    end else if (jump_de) begin
      e = V_JUMP;
    end else if (!ihit) begin
      e = V_IFM;
    end else begin
      e = V_RUN;
    end
    last_obs = obs();
    check(tag, 32'(last_obs), 32'(e));
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; dREN_ex = 0; regDst_ex = '0; dREN_me = 0; dWEN_me = 0;
    pcsel_ex = 0; jump_de = 0; halt_wb = 0; instru_de = '0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1;
    cycle("reset0");
    cycle("reset1");
    RST = 0;
  endtask

  initial begin
    m_halted = 0;
    m_left = 0;
    do_reset();
    check("reset_outputs", 32'(last_obs), 32'(V_RST));
    cycle("run_idle");
    check("run_after_reset", 32'(last_obs), 32'(V_RUN));

    // lw $2 then add $3,$2,$4: two bubbles, RUN on the third cycle
    k = 0;
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_ADD;
    cycle("lu_add_b1"); if (!last_obs[9]) k++;
    dREN_ex = 0;
    cycle("lu_add_b2"); if (!last_obs[9]) k++;
    cycle("lu_add_run"); if (!last_obs[9]) k++;
    check("lu_add_bubbles", 32'(k), 32'd2);
    check("lu_add_cycle3", 32'(last_obs), 32'(V_RUN));

    // lw $2 then jr $2: one bubble, then the jump redirects fetch
    k = 0;
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_JR; jump_de = 1;
    cycle("lu_jr_b1"); if (!last_obs[9]) k++;
    dREN_ex = 0;
    cycle("lu_jr_go"); if (!last_obs[9]) k++;
    check("lu_jr_bubbles", 32'(k), 32'd1);
    check("lu_jr_jump", 32'(last_obs), 32'(V_JUMP));
    jump_de = 0;

    // lw $2 then sw $2: no stall
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_SW;
    cycle("lu_sw");
    check("lu_sw_nostall", 32'(last_obs), 32'(V_RUN));
    idle();

    // dcache miss for four cycles
    k = 0;
    dREN_me = 1; dhit = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("memwait"); if (last_obs[1]) k++;
    end
    check("memwait_cycles", 32'(k), 32'd4);
    dhit = 1;
    cycle("memwait_resume");
    check("memwait_resume_run", 32'(last_obs), 32'(V_RUN));
    idle();

    // load-use together with a taken branch: flush only
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_ADD; pcsel_ex = 1;
    cycle("lu_redirect");
    check("lu_redirect_flush", 32'(last_obs), 32'(V_REDIR));
    idle();
    cycle("lu_redirect_after");
    check("lu_redirect_nostall", 32'(last_obs), 32'(V_RUN));

    // dcache miss after the first bubble holds the remaining bubble
    k = 0;
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_ADD;
    cycle("lu_mem_b1"); if (last_obs == V_BUB) k++;
    dREN_ex = 0; dREN_me = 1; dhit = 0;
    cycle("lu_mem_w1"); if (last_obs == V_BUB) k++;
    cycle("lu_mem_w2"); if (last_obs == V_BUB) k++;
    dhit = 1;
    cycle("lu_mem_b2"); if (last_obs == V_BUB) k++;
    check("lu_mem_bubble2", 32'(last_obs), 32'(V_BUB));
    dREN_me = 0;
    cycle("lu_mem_run");
    check("lu_mem_bubbles", 32'(k), 32'd2);
    idle();

    // reset in the middle of a load-use stall
    dREN_ex = 1; regDst_ex = 5'd2; instru_de = I_ADD;
    cycle("lu_rst_b1");
    dREN_ex = 0; RST = 1;
    cycle("lu_rst_rst");
    RST = 0;
    cycle("lu_rst_after");
    check("lu_rst_no_leftover", 32'(last_obs), 32'(V_RUN));

    // halt is sticky until reset
    halt_wb = 1;
    cycle("halt_enter");
    halt_wb = 0; pcsel_ex = 1; ihit = 0;
    for (int i = 0; i < 3; i++) cycle("halt_hold");
    check("halt_sticky", 32'(last_obs), 32'(V_HALT));
    do_reset();
    cycle("halt_cleared");
    check("halt_cleared_run", 32'(last_obs), 32'(V_RUN));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      logic [31:0] ins;
      op  = ops[$urandom_range(0, 9)];
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      if (op == 6'h00) ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
      instru_de = ins;
      RST       = ($urandom_range(0, 99) < 3);
      halt_wb   = ($urandom_range(0, 199) == 0);
      ihit      = ($urandom_range(0, 99) < 80);
      dREN_me   = ($urandom_range(0, 99) < 20);
      dWEN_me   = ($urandom_range(0, 99) < 10);
      dhit      = ($urandom_range(0, 99) < 60);
      dREN_ex   = ($urandom_range(0, 99) < 50);
      regDst_ex = 5'($urandom_range(0, 3));
      pcsel_ex  = ($urandom_range(0, 99) < 10);
      jump_de   = ($urandom_range(0, 99) < 10);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
